buffer_ptr_ctrl: RTL and testbench

Pointer and occupancy controller for the circular `instant_buffer` window store. It sits directly in front of the buffer.

- Upstream, it accepts WRITE_SIZE-element bursts through a valid/ready handshake.
- It drives the buffer's write-enable and write pointer.
- Downstream, it advances the READ_SIZE-wide read window by STRIDE each time the consumer accepts a window.
- It tracks occupancy, so the buffer never overwrites unread data and never presents an incomplete window.

---
 rtl/buffer_ptr_ctrl_if.sv | 51 +++++
 rtl/buffer_ptr_ctrl.sv | 112 +++++++++++
 tb/tb_buffer_ptr_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_ptr_ctrl_if.sv
// ---------------------------------------------------------------------------
// buffer_ptr_ctrl_if
//
// Groups the handshake and buffer-control signals of buffer_ptr_ctrl.
//
//   clear       flush request (synchronous)
//   in_valid    upstream burst available
//   in_ready    space for one full burst
//   out_ready   consumer accepts the current window
//   out_valid   a complete window is present
//   write_en    buffer load strobe for the current burst
//   write_addr  buffer slot for burst element 0
//   read_addr   buffer slot for window element 0
//   count       number of unread elements held
//   full        count == SIZE
//   empty       count == 0
//
// Modports:
//   master - the surrounding system (producer, consumer, buffer).
//   slave  - the pointer controller itself.
// ---------------------------------------------------------------------------
interface buffer_ptr_ctrl_if #(
    parameter int SIZE = 8
);
    localparam int PTR_W = $clog2(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic             write_en;
    logic [PTR_W-1:0] write_addr;
    logic [PTR_W-1:0] read_addr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (
        output clear, in_valid, out_ready,
        input  in_ready, out_valid, write_en, write_addr, read_addr,
               count, full, empty
    );

    modport slave (
        input  clear, in_valid, out_ready,
        output in_ready, out_valid, write_en, write_addr, read_addr,
               count, full, empty
    );
endinterface

// File: rtl/buffer_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// buffer_ptr_ctrl
//
// Pointer and occupancy controller for a circular window buffer. Accepts
// WRITE_SIZE-element bursts upstream, presents READ_SIZE-element windows
// downstream and advances the read window by STRIDE per accepted window.
// Occupancy tracking keeps the buffer from overwriting unread data and from
// presenting an incomplete window.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   buffer_ptr_ctrl_if.slave (handshakes, buffer pointers, status)
//
// Parameters:
//   SIZE        buffer depth in elements (power of two, >= 2)
//   WRITE_SIZE  elements per accepted burst (1..SIZE)
//   READ_SIZE   elements per output window (1..SIZE)
//   STRIDE      elements freed per accepted window (1..READ_SIZE)
// ---------------------------------------------------------------------------
module buffer_ptr_ctrl #(
    parameter int SIZE       = 8,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 2,
    parameter int STRIDE     = 1
) (
    input logic               clk,
    input logic               rst,
    buffer_ptr_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);

    // Pointer steps; WRITE_SIZE == SIZE folds to a zero step, which is the
    // correct modulo-SIZE advance.
    localparam logic [PTR_W-1:0] WR_STEP = PTR_W'(WRITE_SIZE % SIZE);
    localparam logic [PTR_W-1:0] RD_STEP = PTR_W'(STRIDE % SIZE);

    // Thresholds on the registered count.
    localparam logic [CNT_W-1:0] SPACE_LIMIT = CNT_W'(SIZE - WRITE_SIZE);
    localparam logic [CNT_W-1:0] WINDOW_MIN  = CNT_W'(READ_SIZE);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(SIZE);

    localparam logic [CNT_W:0] CNT_ADD = (CNT_W + 1)'(WRITE_SIZE);
    localparam logic [CNT_W:0] CNT_SUB = (CNT_W + 1)'(STRIDE);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             space_ok;
    logic             window_ok;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   count_next;

    // Space is judged on the registered count only: a pop in this cycle does
    // not make room for a push in the same cycle.
    assign space_ok  = (count <= SPACE_LIMIT);
    assign window_ok = (count >= WINDOW_MIN);

    // in_ready is gated by rst so no handshake can complete while the
    // controller is held in reset.
    assign bus.in_ready  = rst & space_ok;
    assign bus.out_valid = window_ok;

    assign push = bus.in_valid & bus.in_ready & ~bus.clear;
    assign pop  = window_ok & bus.out_ready & ~bus.clear;

    assign bus.write_en   = push;
    assign bus.write_addr = wr_ptr;
    assign bus.read_addr  = rd_ptr;
    assign bus.count      = count;
    assign bus.full       = (count == FULL_COUNT);
    assign bus.empty      = (count == '0);

    // One wider bit keeps count + WRITE_SIZE from overflowing before STRIDE
    // is taken off; the handshake thresholds keep the final value in 0..SIZE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        count_next = {1'b0, count};
        if (push) begin
            count_next = count_next + CNT_ADD;
        end
        if (pop) begin
            count_next = count_next - CNT_SUB;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + WR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + RD_STEP;
            end
            count <= CNT_W'(count_next);
        end
    end
endmodule

// File: tb/tb_buffer_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buffer_ptr_ctrl
//
// Self-checking bench for buffer_ptr_ctrl at the default parameters. The
// reference model holds the unread elements as a queue of buffer slot
// numbers: occupancy is the queue length and the read window starts at the
// slot of the oldest unread element.
// ---------------------------------------------------------------------------
module tb_buffer_ptr_ctrl;
    localparam int SIZE = 8;
    localparam int WS   = 2;
    localparam int RS   = 2;
    localparam int ST   = 1;

    logic clk;
    logic rst;

    buffer_ptr_ctrl_if #(.SIZE(SIZE)) bus ();

    buffer_ptr_ctrl #(
        .SIZE       (SIZE),
        .WRITE_SIZE (WS),
        .READ_SIZE  (RS),
        .STRIDE     (ST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model
    int q[$];        // slots of unread elements, oldest first
    int wr_m = 0;    // next slot to be written
    int rd_m = 0;    // read slot used while nothing is held
    bit rst_m = 1'b0;

    function automatic bit m_in_ready();
        return rst_m && ((SIZE - q.size()) >= WS);
    endfunction

    function automatic bit m_out_valid();
        return q.size() >= RS;
    endfunction

    function automatic int m_read_addr();
        return (q.size() > 0) ? q[0] : rd_m;
    endfunction

    task automatic model_reset();
        q.delete();
        wr_m = 0;
        rd_m = 0;
    endtask

    // Drive inputs after the falling edge and let combinational outputs settle.
    task automatic drive(input bit iv, input bit ordy, input bit clr);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.clear     = clr;
        #1;
    endtask

    // Cross one rising edge and advance the model with the same inputs.
    task automatic tick();
        bit p;
        bit o;
        p = bus.in_valid && m_in_ready() && !bus.clear;
        o = m_out_valid() && bus.out_ready && !bus.clear;
        @(posedge clk);
        if (bus.clear) begin
            model_reset();
        end else begin
            if (o) begin
                for (int i = 0; i < ST; i++) void'(q.pop_front());
                rd_m = (rd_m + ST) % SIZE;
            end
            if (p) begin
                for (int i = 0; i < WS; i++) q.push_back((wr_m + i) % SIZE);
                wr_m = (wr_m + WS) % SIZE;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.write_en !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: write_en=%b in_ready=%b expected 0 0",
                     bus.write_en, bus.in_ready);
        end
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b out_valid=%b expected 0 1 0 0",
                     bus.count, bus.empty, bus.full, bus.out_valid);
        end
        checks++;
        if (bus.write_addr !== 3'd0 || bus.read_addr !== 3'd0) begin
            failures++;
            $display("FAIL reset_addr: write_addr=%0d read_addr=%0d expected 0 0",
                     bus.write_addr, bus.read_addr);
        end
        bus.in_valid = 1'b0;
        rst   = 1'b1;
        rst_m = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.count !== 4'd0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b count=%0d expected 1 0",
                     bus.in_ready, bus.count);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.write_en !== 1'b1 || bus.write_addr !== 3'(2 * i)) begin
                failures++;
                $display("FAIL fill_write%0d: write_en=%b write_addr=%0d expected 1 %0d",
                         i, bus.write_en, bus.write_addr, 2 * i);
            end
            tick();
            checks++;
            if (bus.count !== 4'(2 * (i + 1))) begin
                failures++;
                $display("FAIL fill_count%0d: count=%0d expected %0d",
                         i, bus.count, 2 * (i + 1));
            end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: full=%b in_ready=%b expected 1 0",
                     bus.full, bus.in_ready);
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.write_en !== 1'b0) begin
            failures++;
            $display("FAIL fill_held_write: write_en=%b expected 0", bus.write_en);
        end
        tick();
        checks++;
        if (bus.count !== 4'd8 || bus.write_addr !== 3'd0) begin
            failures++;
            $display("FAIL fill_held_state: count=%0d write_addr=%0d expected 8 0",
                     bus.count, bus.write_addr);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.read_addr !== 3'(i) || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL wrap_pop%0d: read_addr=%0d out_valid=%b expected %0d 1",
                         i, bus.read_addr, bus.out_valid, i);
            end
            tick();
        end
        checks++;
        if (bus.read_addr !== 3'd2 || bus.count !== 4'd6 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL wrap_after_pops: read_addr=%0d count=%0d in_ready=%b expected 2 6 1",
                     bus.read_addr, bus.count, bus.in_ready);
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd0) begin
            failures++;
            $display("FAIL wrap_push: write_en=%b write_addr=%0d expected 1 0",
                     bus.write_en, bus.write_addr);
        end
        tick();
        checks++;
        if (bus.count !== 4'd8) begin
            failures++;
            $display("FAIL wrap_push_count: count=%0d expected 8", bus.count);
        end
        // Eight pops with pushes refilling whenever space allows.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.read_addr !== 3'((2 + i) % SIZE)) begin
                failures++;
                $display("FAIL wrap_read%0d: out_valid=%b read_addr=%0d expected 1 %0d",
                         i, bus.out_valid, bus.read_addr, (2 + i) % SIZE);
            end
            tick();
            checks++;
            if (bus.count !== 4'(q.size()) || bus.write_addr !== 3'(wr_m)) begin
                failures++;
                $display("FAIL wrap_state%0d: count=%0d write_addr=%0d expected %0d %0d",
                         i, bus.count, bus.write_addr, q.size(), wr_m);
            end
        end
        checks++;
        if (bus.read_addr !== 3'd2) begin
            failures++;
            $display("FAIL wrap_final_read: read_addr=%0d expected 2", bus.read_addr);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (bus.count !== 4'd4 || bus.write_addr !== 3'd4 || bus.read_addr !== 3'd0) begin
            failures++;
            $display("FAIL simul_setup: count=%0d write_addr=%0d read_addr=%0d expected 4 4 0",
                     bus.count, bus.write_addr, bus.read_addr);
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.write_en !== 1'b1 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL simul_handshake: write_en=%b out_valid=%b expected 1 1",
                     bus.write_en, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.count !== 4'd5 || bus.write_addr !== 3'd6 || bus.read_addr !== 3'd1) begin
            failures++;
            $display("FAIL simul_result: count=%0d write_addr=%0d read_addr=%0d expected 5 6 1",
                     bus.count, bus.write_addr, bus.read_addr);
        end
    endtask

    task automatic test_clear();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (bus.count !== 4'd6) begin
            failures++;
            $display("FAIL clear_setup: count=%0d expected 6", bus.count);
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.write_en !== 1'b0) begin
            failures++;
            $display("FAIL clear_write_en: write_en=%b expected 0", bus.write_en);
        end
        tick();
        checks++;
        if (bus.count !== 4'd0 || bus.write_addr !== 3'd0 || bus.read_addr !== 3'd0 ||
            bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_result: count=%0d wa=%0d ra=%0d empty=%b out_valid=%b expected 0 0 0 1 0",
                     bus.count, bus.write_addr, bus.read_addr, bus.empty, bus.out_valid);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.count !== 4'd5) begin
            failures++;
            $display("FAIL areset_setup: count=%0d expected 5", bus.count);
        end
        // Assert reset between edges with a request pending.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #2;
        rst   = 1'b0;
        rst_m = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.write_addr !== 3'd0 || bus.read_addr !== 3'd0 ||
            bus.in_ready !== 1'b0 || bus.write_en !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: count=%0d wa=%0d ra=%0d in_ready=%b write_en=%b expected 0 0 0 0 0",
                     bus.count, bus.write_addr, bus.read_addr, bus.in_ready, bus.write_en);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst   = 1'b1;
        rst_m = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd0) begin
            failures++;
            $display("FAIL areset_resume_write: write_en=%b write_addr=%0d expected 1 0",
                     bus.write_en, bus.write_addr);
        end
        tick();
        checks++;
        if (bus.count !== 4'd2 || bus.write_addr !== 3'd2) begin
            failures++;
            $display("FAIL areset_resume_state: count=%0d write_addr=%0d expected 2 2",
                     bus.count, bus.write_addr);
        end
    endtask

    task automatic test_random();
        logic [14:0] got;
        logic [14:0] exp;
        bit iv;
        bit ordy;
        bit clr;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            drive(iv, ordy, clr);
            exp = {iv && m_in_ready() && !clr, m_in_ready(), m_out_valid(),
                   q.size() == SIZE, q.size() == 0, 4'(q.size()),
                   3'(wr_m), 3'(m_read_addr())};
            got = {bus.write_en, bus.in_ready, bus.out_valid, bus.full, bus.empty,
                   bus.count, bus.write_addr, bus.read_addr};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random%0d: {we,ir,ov,full,empty,count,wa,ra}=%b expected %b",
                         n, got, exp);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst           = 1'b0;
        rst_m         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        model_reset();

        test_reset();
        test_fill_full();
        test_wrap();
        test_simultaneous();
        test_clear();
        test_async_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
